// File: rtl/flash_scan_pkg.sv
// Shared types and default timing constants for the flash_scan sequencer.
package flash_scan_pkg;

  // Sequencer states; exported on the scan_state debug port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_GAP   = 3'd4
  } scan_state_t;

  // Default read latency of the flash controller and idle gap between reads.
  localparam int DEF_LAT = 64;
  localparam int DEF_GAP = 4;

endpackage

// File: rtl/flash_scan_check.sv
// Pattern checker for flash_scan: compares each captured word with seed+idx,
// keeps a saturating mismatch count and the index of the first mismatch.
// Only instantiated when FLASH_SCAN_CHECK_EN is defined.
module flash_scan_check #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              capt,
  input  logic              first,
  input  logic [CNT_W-1:0]  idx,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] seed,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err
);

  logic mismatch;

  assign mismatch = (data != (seed + DATA_W'(idx)));

  // Error statistics restart on a new scan and on the first capture of each pass.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_cnt   <= '0;
      first_err <= '1;
    end else if (capt) begin
      if (first) begin
        err_cnt   <= mismatch ? CNT_W'(1) : '0;
        first_err <= mismatch ? idx : '1;
      end else if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (err_cnt == '0) first_err <= idx;
      end
    end
  end

endmodule

// File: rtl/flash_scan.sv
// flash_scan: issues a programmable burst of word reads to the flash read
// controller, spacing reads by a fixed latency, and reports each word with a
// running checksum. Optional pattern checking under FLASH_SCAN_CHECK_EN.
//
// Handshake: start is a one-cycle request accepted only while busy is low
// and abort is low; there is no backpressure on the output side, so
// word_valid and done are single-cycle strobes the consumer must take.
module flash_scan
  import flash_scan_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int LAT    = DEF_LAT,
  parameter int GAP    = DEF_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        step,
  input  logic [CNT_W-1:0]  count,
  input  logic              loop,
`ifdef FLASH_SCAN_CHECK_EN
  input  logic [DATA_W-1:0] seed,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err,
`endif
  output logic              busy,
  output logic              done,
  output logic              flash_cs,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [DATA_W-1:0] flash_dout,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic [CNT_W-1:0]  idx,
  output logic [DATA_W-1:0] sum,
  output scan_state_t       scan_state
);

  localparam int TMR_W = $clog2(LAT + GAP + 1) + 1;

  scan_state_t       state, next_state;
  logic [ADDR_W-1:0] base_r;
  logic [7:0]        step_r;
  logic [CNT_W-1:0]  count_r;
  logic              loop_r;
  logic [TMR_W-1:0]  tmr;
  logic              accept, last, capt_ok, wait_done, gap_done;

  // busy also covers the cycle after the final capture, so a start there is dropped.
  assign accept    = (state == S_IDLE) && start && !busy && !abort;
  assign last      = (idx == (count_r - CNT_W'(1)));
  assign capt_ok   = (state == S_CAPT) && !abort;
  assign wait_done = (tmr == TMR_W'(LAT - 2));
  assign gap_done  = (tmr == TMR_W'(GAP - 1));
  assign scan_state = state;

  // Next-state selection; abort overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept && (count != '0)) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (wait_done) next_state = S_CAPT;
      S_CAPT: begin
        if (last && !loop_r) next_state = S_IDLE;
        else                 next_state = (GAP == 0) ? S_ISSUE : S_GAP;
      end
      S_GAP:   if (gap_done) next_state = S_ISSUE;
      default: next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // Dwell timer for WAIT and GAP, restarted on every state change.
  always_ff @(posedge clk) begin
    if (reset || (next_state != state)) tmr <= '0;
    else                                tmr <= tmr + TMR_W'(1);
  end

  // State register, latched parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      flash_cs   <= 1'b0;
      word_valid <= 1'b0;
      flash_addr <= '0;
      word       <= '0;
      idx        <= '0;
      sum        <= '0;
      base_r     <= '0;
      step_r     <= '0;
      count_r    <= '0;
      loop_r     <= 1'b0;
    end else begin
      state      <= next_state;
      flash_cs   <= (next_state == S_ISSUE);
      busy       <= (next_state != S_IDLE) || capt_ok;
      word_valid <= capt_ok;
      done       <= (capt_ok && last) || (accept && (count == '0));
      if (accept) begin
        base_r  <= base;
        step_r  <= step;
        count_r <= count;
        loop_r  <= loop;
        idx     <= '0;
        if (count != '0) flash_addr <= base;
      end
      if (capt_ok) begin
        word <= flash_dout;
        sum  <= (idx == '0) ? flash_dout : sum + flash_dout;
        if (last) begin
          if (loop_r) begin
            idx        <= '0;
            flash_addr <= base_r;
          end
        end else begin
          idx        <= idx + CNT_W'(1);
          flash_addr <= flash_addr + ADDR_W'(step_r);
        end
      end
    end
  end

`ifdef FLASH_SCAN_CHECK_EN
  logic [DATA_W-1:0] seed_r;

  // Seed is captured with the other scan parameters.
  always_ff @(posedge clk) begin
    if (reset)       seed_r <= '0;
    else if (accept) seed_r <= seed;
  end

  flash_scan_check #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_check (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .capt      (capt_ok),
    .first     (idx == '0),
    .idx       (idx),
    .data      (flash_dout),
    .seed      (seed_r),
    .err_cnt   (err_cnt),
    .first_err (first_err)
  );
`endif

endmodule

// File: tb/tb_flash_scan.sv
// Testbench for flash_scan (LAT=8, GAP=2). Pattern-check tests are compiled
// when FLASH_SCAN_CHECK_EN is defined.
module tb_flash_scan;
  import flash_scan_pkg::*;

  localparam int LAT = 8;
  localparam int GAP = 2;
  localparam int PER = LAT + 1 + GAP;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset, start, abort, loop;
  logic [21:0] base;
  logic [7:0]  step;
  logic [15:0] count;
  logic        busy, done, flash_cs, word_valid;
  logic [21:0] flash_addr;
  logic [15:0] flash_dout, word, idx, sum;
  scan_state_t scan_state;
`ifdef FLASH_SCAN_CHECK_EN
  logic [15:0] seed, err_cnt, first_err;
`endif

  always #5 clk = ~clk;

  flash_scan #(
    .ADDR_W (22), .DATA_W (16), .CNT_W (16), .LAT (LAT), .GAP (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base       (base),
    .step       (step),
    .count      (count),
    .loop       (loop),
`ifdef FLASH_SCAN_CHECK_EN
    .seed       (seed),
    .err_cnt    (err_cnt),
    .first_err  (first_err),
`endif
    .busy       (busy),
    .done       (done),
    .flash_cs   (flash_cs),
    .flash_addr (flash_addr),
    .flash_dout (flash_dout),
    .word       (word),
    .word_valid (word_valid),
    .idx        (idx),
    .sum        (sum),
    .scan_state (scan_state)
  );

  // Flash contents: low address bits, optionally xored with a key and with
  // words 5 and 9 corrupted.
  logic [15:0] key;
  logic        corrupt_en;

  function automatic logic [15:0] model_word(input logic [21:0] a);
    logic [15:0] w;
    w = a[15:0] ^ key;
    if (corrupt_en && (a == 22'd5 || a == 22'd9)) w = w ^ 16'h8000;
    return w;
  endfunction

  always_comb flash_dout = model_word(flash_addr);

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [21:0] got_first_addr, got_last_addr;
  int          got_last_vcyc;

  // Runs one non-looping pass and checks it against the expected read list.
  task automatic run_scan(input logic [21:0] b, input logic [7:0] s,
                          input logic [15:0] c, input int poke_cyc);
    logic [21:0] exp_addr_q[$];
    logic [15:0] exp_word_q[$];
    logic [15:0] exp_sum_q[$];
    int          exp_cyc_q[$];
    logic [15:0] acc, w;
    logic [21:0] a;
    int          cyc, budget, k, last_vcyc;
    acc = '0;
    for (int i = 0; i < int'(c); i++) begin
      a = b + 22'(i) * 22'(s);
      w = model_word(a);
      acc = (i == 0) ? w : acc + w;
      exp_addr_q.push_back(a);
      exp_word_q.push_back(w);
      exp_sum_q.push_back(acc);
      exp_cyc_q.push_back(2 + LAT + i * PER);
    end
    last_vcyc = 2 + LAT + (int'(c) - 1) * PER;
    budget = last_vcyc + 8;
    got_first_addr = 'x;
    got_last_vcyc = -1;
    base = b; step = s; count = c; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("busy_rise", busy, 1);
    while (cyc < budget) begin
      if (cyc == poke_cyc) begin
        start = 1'b1; base = ~b; step = s + 8'd1; count = c + 16'd1;
      end else begin
        start = 1'b0;
      end
      if (flash_cs) begin
        if (exp_addr_q.size() == 0) chk("extra_cs", 1, 0);
        else begin
          k = int'(c) - exp_addr_q.size();
          a = exp_addr_q.pop_front();
          if (k == 0) got_first_addr = flash_addr;
          got_last_addr = flash_addr;
          chk("addr", flash_addr, a);
          chk("idx_at_cs", idx, k);
        end
      end
      if (word_valid) begin
        if (exp_word_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          chk("word", word, exp_word_q.pop_front());
          chk("sum", sum, exp_sum_q.pop_front());
          chk("vcyc", cyc, exp_cyc_q.pop_front());
          chk("done_with_last", done, exp_word_q.size() == 0);
          got_last_vcyc = cyc;
        end
      end else if (done) begin
        chk("stray_done", 1, 0);
      end
      if (!busy) break;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("busy_fall_cyc", cyc, last_vcyc + 1);
    chk("words_left", exp_word_q.size(), 0);
    chk("idx_end", idx, c - 16'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [21:0] b;
    logic [7:0]  s;
    logic [15:0] c;
    int          poke;
    logic [21:0] first_a;
    logic [21:0] last_a;
    logic [15:0] sum;
    int          last_vcyc;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc;
    logic any;
    int cs_q[$];
    int wv_q[$];
    int dn_q[$];
    logic busy_low;

    tbl[0] = '{22'h080000, 8'd1,    16'd4, 5,  22'h080000, 22'h080003, 16'h0006, 43};
    tbl[1] = '{22'h3FFFFE, 8'd3,    16'd3, 32, 22'h3FFFFE, 22'h000004, 16'h0003, 32};
    tbl[2] = '{22'h123456, 8'h10,   16'd1, 0,  22'h123456, 22'h123456, 16'h3456, 10};
    tbl[3] = '{22'h000000, 8'hFF,   16'd5, 13, 22'h000000, 22'h0003FC, 16'h09F6, 54};

    reset = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    base = '0; step = '0; count = '0; key = '0; corrupt_en = 1'b0;
`ifdef FLASH_SCAN_CHECK_EN
    seed = '0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_ctrl", {busy, done, flash_cs, word_valid, idx, sum}, 0);
    chk("reset_data", {flash_addr, word}, 0);
    chk("reset_state", 64'(scan_state), 64'(S_IDLE));

    // Table-driven single passes.
    for (int i = 0; i < 4; i++) begin
      run_scan(tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].poke);
      chk("tbl_first_addr", got_first_addr, tbl[i].first_a);
      chk("tbl_last_addr", got_last_addr, tbl[i].last_a);
      chk("tbl_sum", sum, tbl[i].sum);
      chk("tbl_last_vcyc", got_last_vcyc, tbl[i].last_vcyc);
      tick();
      chk("tbl_stays_idle", busy, 0);
`ifdef FLASH_SCAN_CHECK_EN
      if (i == 0) begin
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_first_err", first_err, 16'hFFFF);
      end
`endif
    end

    // Randomized passes against the read-list model.
    for (int r = 0; r < 6; r++) begin
      key = 16'($urandom);
      run_scan(22'($urandom), 8'($urandom_range(0, 255)), 16'($urandom_range(1, 5)), 0);
      tick();
    end
    key = '0;

    // count = 0: done in cycle 1, nothing else.
    count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done_c1", done, 1);
    chk("zero_busy_c1", busy, 0);
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any = any | busy | flash_cs | done;
    end
    chk("zero_quiet", any, 0);

    // abort and start together while idle: abort wins.
    count = 16'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    any = busy | flash_cs;
    for (int i = 0; i < 3; i++) begin
      tick();
      any = any | busy | flash_cs;
    end
    chk("abort_start_idle", any, 0);

    // Looping scan aborted during the third WAIT.
    base = 22'h000100; step = 8'd1; count = 16'd2; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    busy_low = 1'b0;
    cyc = 1;
    while (cyc <= 26) begin
      if (flash_cs) cs_q.push_back(cyc);
      if (word_valid) wv_q.push_back(cyc);
      if (done) dn_q.push_back(cyc);
      if (!busy) busy_low = 1'b1;
      if (cyc == 26) abort = 1'b1;
      tick();
      cyc++;
    end
    abort = 1'b0;
    chk("loop_busy_held", busy_low, 0);
    chk("loop_cs_n", cs_q.size(), 3);
    if (cs_q.size() == 3) chk("loop_cs3_cyc", cs_q[2], 23);
    chk("loop_wv_n", wv_q.size(), 2);
    if (wv_q.size() == 2) chk("loop_wv2_cyc", wv_q[1], 21);
    chk("loop_done_n", dn_q.size(), 1);
    if (dn_q.size() == 1) chk("loop_done_cyc", dn_q[0], 21);
    chk("abort_busy_low", busy, 0);
    any = 1'b0;
    for (int i = 0; i < 30; i++) begin
      any = any | word_valid | done | flash_cs | busy;
      tick();
    end
    chk("abort_quiet", any, 0);
    chk("abort_sum_held", sum, 16'h0201);
    chk("abort_word_held", word, 16'h0101);
    run_scan(22'h000040, 8'd2, 16'd2, 0);
    tick();

`ifdef FLASH_SCAN_CHECK_EN
    // Pattern check: words equal idx except two corrupted entries.
    corrupt_en = 1'b1; seed = 16'h0000;
    run_scan(22'h000000, 8'd1, 16'd16, 0);
    chk("chk_err_cnt", err_cnt, 2);
    chk("chk_first_err", first_err, 5);
    corrupt_en = 1'b0;
    tick();
`endif

    // Reset in the middle of WAIT clears everything.
    base = 22'h000055; step = 8'd1; count = 16'd3; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_ctrl", {busy, done, flash_cs, word_valid, idx, sum}, 0);
    chk("midreset_data", {flash_addr, word}, 0);
    chk("midreset_state", 64'(scan_state), 64'(S_IDLE));
    any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any = any | busy | word_valid | flash_cs;
    end
    chk("midreset_quiet", any, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog in case a scan never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
